// File: rtl/dest_sel_pipe.sv
// Destination-register selector feeding a STAGES-deep pipeline with per-stage hazard match.
// Stage registers are updated every edge; stall/flush shape stages 0 and 1, later stages free-run.
module dest_sel_pipe #(
    parameter int ADDR_W        = 5,
    parameter int NUM_SRC       = 3,
    parameter int STAGES        = 3,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [NUM_SRC*ADDR_W-1:0]   src_addr,
    input  logic [$clog2(NUM_SRC)-1:0]  sel,
    input  logic                        in_valid,
    input  logic                        reg_write_in,
    input  logic                        stall,
    input  logic                        flush,
    output logic [STAGES*ADDR_W-1:0]    dest_addr,
    output logic [STAGES-1:0]           dest_we,
    output logic [ADDR_W-1:0]           wb_addr,
    output logic                        wb_we,
    input  logic [ADDR_W-1:0]           rs_q,
    input  logic [ADDR_W-1:0]           rt_q,
    output logic [STAGES-1:0]           rs_hit,
    output logic [STAGES-1:0]           rt_hit
);

    logic [STAGES-1:0][ADDR_W-1:0] st_addr;
    logic [STAGES-1:0]             st_we;
    logic [ADDR_W-1:0]             cand;
    logic                          cand_we;
    logic                          sel_ok;

    always_comb begin
        cand   = '0;
        sel_ok = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(sel) == i) begin
                cand   = src_addr[i*ADDR_W +: ADDR_W];
                sel_ok = 1'b1;
            end
        end
        // An out-of-range index behaves like a non-writing instruction to address 0.
        cand_we = sel_ok & in_valid & reg_write_in;
        if ((ZERO_SUPPRESS != 0) && (cand == '0))
            cand_we = 1'b0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            st_addr <= '0;
            st_we   <= '0;
        end else begin
            if (flush) begin
                st_addr[0] <= '0;
                st_we[0]   <= 1'b0;
            end else if (!stall) begin
                st_addr[0] <= in_valid ? cand : '0;
                st_we[0]   <= in_valid & cand_we;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (k == 1 && stall) begin
                    st_addr[k] <= '0;
                    st_we[k]   <= 1'b0;
                end else begin
                    st_addr[k] <= st_addr[k-1];
                    st_we[k]   <= st_we[k-1];
                end
            end
        end
    end

    assign dest_addr = st_addr;
    assign dest_we   = st_we;
    assign wb_addr   = st_addr[STAGES-1];
    assign wb_we     = st_we[STAGES-1];

    // Query address 0 is the hard-wired zero register and never needs forwarding.
    always_comb begin
        rs_hit = '0;
        rt_hit = '0;
        for (int k = 0; k < STAGES; k++) begin
            rs_hit[k] = st_we[k] & (st_addr[k] == rs_q) & (rs_q != '0);
            rt_hit[k] = st_we[k] & (st_addr[k] == rt_q) & (rt_q != '0);
        end
    end

endmodule

// File: tb/tb_dest_sel_pipe.sv
// Table-driven check of dest_sel_pipe (default build plus a ZERO_SUPPRESS=0 build).
module tb_dest_sel_pipe;
    localparam int AW = 5;
    localparam int NS = 3;
    localparam int ST = 3;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [NS*AW-1:0]  src_addr;
    logic [1:0]        sel;
    logic              in_valid, reg_write_in, stall, flush;
    logic [AW-1:0]     rs_q, rt_q;

    logic [ST*AW-1:0]  dest_addr, z_dest_addr;
    logic [ST-1:0]     dest_we, z_dest_we;
    logic [AW-1:0]     wb_addr, z_wb_addr;
    logic              wb_we, z_wb_we;
    logic [ST-1:0]     rs_hit, rt_hit, z_rs_hit, z_rt_hit;

    always #5 Clk = ~Clk;

    dest_sel_pipe #(.ADDR_W(AW), .NUM_SRC(NS), .STAGES(ST), .ZERO_SUPPRESS(1)) u_dut (
        .Clk(Clk), .Reset(Reset), .src_addr(src_addr), .sel(sel),
        .in_valid(in_valid), .reg_write_in(reg_write_in), .stall(stall), .flush(flush),
        .dest_addr(dest_addr), .dest_we(dest_we), .wb_addr(wb_addr), .wb_we(wb_we),
        .rs_q(rs_q), .rt_q(rt_q), .rs_hit(rs_hit), .rt_hit(rt_hit)
    );

    dest_sel_pipe #(.ADDR_W(AW), .NUM_SRC(NS), .STAGES(ST), .ZERO_SUPPRESS(0)) u_nozs (
        .Clk(Clk), .Reset(Reset), .src_addr(src_addr), .sel(sel),
        .in_valid(in_valid), .reg_write_in(reg_write_in), .stall(stall), .flush(flush),
        .dest_addr(z_dest_addr), .dest_we(z_dest_we), .wb_addr(z_wb_addr), .wb_we(z_wb_we),
        .rs_q(rs_q), .rt_q(rt_q), .rs_hit(z_rs_hit), .rt_hit(z_rt_hit)
    );

    typedef struct {
        logic [14:0] src;
        logic [1:0]  sel;
        logic        valid, wr, stall, flush;
        logic [4:0]  rsq, rtq;
        logic [14:0] exp_addr;   // {stage2, stage1, stage0}
        logic [2:0]  exp_we;
        logic        exp_zwe;    // stage-0 we of the ZERO_SUPPRESS=0 build
        logic [2:0]  exp_rs, exp_rt;
    } vec_t;

    localparam logic [14:0] SA = {5'd31, 5'd8, 5'd9};
    localparam logic [14:0] SB = {5'd0, 5'd12, 5'd5};
    localparam logic [14:0] SC = {5'd0, 5'd7, 5'd7};
    localparam int NV = 22;

    vec_t vecs [NV];
    int errors = 0;
    int checks = 0;

    function automatic vec_t mk(logic [14:0] src, logic [1:0] s, logic v, logic w, logic stl,
                                logic fl, logic [4:0] rsq, logic [4:0] rtq, logic [14:0] ea,
                                logic [2:0] ewe, logic ezwe, logic [2:0] ers, logic [2:0] ert);
        vec_t r;
        r.src = src; r.sel = s; r.valid = v; r.wr = w; r.stall = stl; r.flush = fl;
        r.rsq = rsq; r.rtq = rtq; r.exp_addr = ea; r.exp_we = ewe; r.exp_zwe = ezwe;
        r.exp_rs = ers; r.exp_rt = ert;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_addr"}, 0, 32'(dest_addr), 32'd0);
        chk({name, "_we"},   0, 32'(dest_we),   32'd0);
        chk({name, "_wb"},   0, {26'd0, wb_we, wb_addr}, 32'd0);
        chk({name, "_hit"},  0, {26'd0, rs_hit, rt_hit}, 32'd0);
    endtask

    initial begin
        //                src sel v  w  st fl rsq    rtq    {s2,s1,s0}              we    zwe rs     rt
        vecs[0]  = mk(SA, 0, 1, 1, 0, 0, 5'd0,  5'd0,  {5'd0, 5'd0, 5'd9},     3'b001, 1, 3'b000, 3'b000);
        vecs[1]  = mk(SA, 1, 1, 1, 0, 0, 5'd0,  5'd0,  {5'd0, 5'd9, 5'd8},     3'b011, 1, 3'b000, 3'b000);
        vecs[2]  = mk(SA, 2, 1, 1, 0, 0, 5'd8,  5'd9,  {5'd9, 5'd8, 5'd31},    3'b111, 1, 3'b010, 3'b100);
        vecs[3]  = mk(SA, 0, 0, 1, 0, 0, 5'd31, 5'd0,  {5'd8, 5'd31, 5'd0},    3'b110, 0, 3'b010, 3'b000);
        vecs[4]  = mk(SA, 0, 0, 1, 0, 0, 5'd31, 5'd0,  {5'd31, 5'd0, 5'd0},    3'b100, 0, 3'b100, 3'b000);
        vecs[5]  = mk(SB, 0, 1, 1, 0, 0, 5'd5,  5'd0,  {5'd0, 5'd0, 5'd5},     3'b001, 1, 3'b001, 3'b000);
        vecs[6]  = mk(SB, 1, 1, 1, 0, 0, 5'd5,  5'd12, {5'd0, 5'd5, 5'd12},    3'b011, 1, 3'b010, 3'b001);
        vecs[7]  = mk(SB, 0, 1, 1, 1, 0, 5'd12, 5'd5,  {5'd5, 5'd0, 5'd12},    3'b101, 1, 3'b001, 3'b100);
        vecs[8]  = mk(SB, 0, 1, 1, 1, 0, 5'd12, 5'd0,  {5'd0, 5'd0, 5'd12},    3'b001, 1, 3'b001, 3'b000);
        vecs[9]  = mk(SB, 0, 0, 1, 0, 0, 5'd12, 5'd0,  {5'd0, 5'd12, 5'd0},    3'b010, 0, 3'b010, 3'b000);
        vecs[10] = mk(SB, 0, 1, 1, 0, 0, 5'd12, 5'd5,  {5'd12, 5'd0, 5'd5},    3'b101, 1, 3'b100, 3'b001);
        vecs[11] = mk(SB, 1, 1, 1, 0, 1, 5'd5,  5'd0,  {5'd0, 5'd5, 5'd0},     3'b010, 0, 3'b010, 3'b000);
        vecs[12] = mk(SB, 1, 1, 1, 0, 0, 5'd5,  5'd12, {5'd5, 5'd0, 5'd12},    3'b101, 1, 3'b100, 3'b001);
        vecs[13] = mk(SB, 0, 1, 1, 1, 1, 5'd5,  5'd12, {5'd0, 5'd0, 5'd0},     3'b000, 0, 3'b000, 3'b000);
        vecs[14] = mk(SB, 2, 1, 1, 0, 0, 5'd0,  5'd0,  {5'd0, 5'd0, 5'd0},     3'b000, 1, 3'b000, 3'b000);
        vecs[15] = mk(SB, 3, 1, 1, 0, 0, 5'd0,  5'd0,  {5'd0, 5'd0, 5'd0},     3'b000, 0, 3'b000, 3'b000);
        vecs[16] = mk(SB, 1, 1, 0, 0, 0, 5'd12, 5'd0,  {5'd0, 5'd0, 5'd12},    3'b000, 0, 3'b000, 3'b000);
        vecs[17] = mk(SC, 0, 1, 1, 0, 0, 5'd7,  5'd12, {5'd0, 5'd12, 5'd7},    3'b001, 1, 3'b001, 3'b000);
        vecs[18] = mk(SC, 0, 1, 0, 0, 0, 5'd7,  5'd12, {5'd12, 5'd7, 5'd7},    3'b010, 0, 3'b010, 3'b000);
        vecs[19] = mk(SC, 0, 1, 1, 0, 0, 5'd7,  5'd0,  {5'd7, 5'd7, 5'd7},     3'b101, 1, 3'b101, 3'b000);
        vecs[20] = mk(SC, 0, 1, 1, 0, 0, 5'd7,  5'd0,  {5'd7, 5'd7, 5'd7},     3'b011, 1, 3'b011, 3'b000);
        vecs[21] = mk(SC, 0, 1, 1, 0, 0, 5'd7,  5'd7,  {5'd7, 5'd7, 5'd7},     3'b111, 1, 3'b111, 3'b111);

        Reset = 1'b1;
        src_addr = SA; sel = 2'd1; in_valid = 1'b1; reg_write_in = 1'b1;
        stall = 1'b0; flush = 1'b0; rs_q = 5'd8; rt_q = 5'd8;
        #3;
        chk_zero("por");
        @(posedge Clk); #1;
        chk_zero("por_held");
        Reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            src_addr = vecs[i].src; sel = vecs[i].sel; in_valid = vecs[i].valid;
            reg_write_in = vecs[i].wr; stall = vecs[i].stall; flush = vecs[i].flush;
            rs_q = vecs[i].rsq; rt_q = vecs[i].rtq;
            @(posedge Clk); #1;
            chk("addr",    i, 32'(dest_addr), 32'(vecs[i].exp_addr));
            chk("we",      i, 32'(dest_we),   32'(vecs[i].exp_we));
            chk("wb",      i, {26'd0, wb_we, wb_addr}, {26'd0, vecs[i].exp_we[2], vecs[i].exp_addr[14:10]});
            chk("rs_hit",  i, 32'(rs_hit),    32'(vecs[i].exp_rs));
            chk("rt_hit",  i, 32'(rt_hit),    32'(vecs[i].exp_rt));
            chk("nozs_we0", i, 32'(z_dest_we[0]), 32'(vecs[i].exp_zwe));
            chk("nozs_rt",  i, 32'(z_rt_hit),  32'(vecs[i].exp_rt));
        end

        // Mid-stream async reset while every stage holds we=1 for address 7.
        #3;
        Reset = 1'b1;
        #1;
        chk_zero("arst");
        @(posedge Clk); #1;
        chk_zero("arst_held");
        Reset = 1'b0;
        src_addr = SA; sel = 2'd1; in_valid = 1'b1; reg_write_in = 1'b1;
        stall = 1'b0; flush = 1'b0; rs_q = 5'd8; rt_q = 5'd0;
        @(posedge Clk); #1;
        chk("post_rst_addr", 0, 32'(dest_addr), 32'({5'd0, 5'd0, 5'd8}));
        chk("post_rst_we",   0, 32'(dest_we),   32'd1);
        chk("post_rst_rs",   0, 32'(rs_hit),    32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
